// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci LFSR PRBS source with clock enable, runtime seed load
// and all-zero lock-up recovery. Define LFSR_PERIOD_EN to add WRAP/PERIOD measurement.
module lfsr_prbs_gen #(
  parameter int unsigned          WIDTH = 16,
  parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0]     SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  output logic [WIDTH-1:0] q_o,
  output logic             lockup_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             lockup_q, lockup_d;
  logic             fb_c;
  logic             zero_c;

  // Next state: lock-up recovery beats LOAD, which beats EN; RESET is in the flop.
  always_comb begin
    fb_c     = ^(q_q & TAPS);
    zero_c   = (q_q == '0);
    q_d      = q_q;
    lockup_d = 1'b0;
    if (zero_c) begin
      q_d      = SEED;
      lockup_d = 1'b1;
    end else if (load_i) begin
      q_d = seed_in_i;
    end else if (en_i) begin
      q_d = {q_q[WIDTH-2:0], fb_c};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q      <= SEED;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      lockup_q <= lockup_d;
    end
  end

  assign q_o      = q_q;
  assign lockup_o = lockup_q;

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cnt_inc_c;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;

  // Step counter saturates so an unrevisited start value never fakes a wrap.
  always_comb begin
    cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
    start_d   = start_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    wrap_d    = 1'b0;
    if (zero_c) begin
      start_d = SEED;
      cnt_d   = '0;
    end else if (load_i) begin
      start_d = seed_in_i;
      cnt_d   = '0;
    end else if (en_i) begin
      if (q_d == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc_c;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc_c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
    end
  end

  assign wrap_o   = wrap_q;
  assign period_o = period_q;
`else
  assign wrap_o   = 1'b0;
  assign period_o = '0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Self-checking bench for lfsr_prbs_gen: directed test-plan cases plus random
// stimulus compared cycle by cycle against an arithmetic reference model.
module tb_lfsr_prbs_gen;

  localparam int unsigned WIDTH = 16;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          MAXP  = 65535;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             en_i = 1'b0;
  logic             load_i = 1'b0;
  logic [WIDTH-1:0] seed_in_i = '0;
  logic [WIDTH-1:0] q_o;
  logic             lockup_o;
  logic             wrap_o;
  logic [WIDTH-1:0] period_o;

  lfsr_prbs_gen #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .load_i(load_i),
    .seed_in_i(seed_in_i), .q_o(q_o), .lockup_o(lockup_o),
    .wrap_o(wrap_o), .period_o(period_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_q = 0, m_start = 0, m_cnt = 0, m_period = 0;
  bit m_lock = 0, m_wrap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // polynomial step: shift left by doubling, feed back the parity of the tapped bits
  function automatic int ref_step(input int v);
    int par;
    par = $countones(32'(v) & 32'(TAPS)) % 2;
    return (v * 2 + par) % 65536;
  endfunction

  task automatic model_update(input bit r, input bit e, input bit l, input int s);
    m_lock = 0;
    m_wrap = 0;
    if (r) begin
      m_q = SEED; m_start = SEED; m_cnt = 0; m_period = 0;
    end else if (m_q == 0) begin
      m_q = SEED; m_start = SEED; m_cnt = 0; m_lock = 1;
    end else if (l) begin
      m_q = s; m_start = s; m_cnt = 0;
    end else if (e) begin
      m_q = ref_step(m_q);
      m_cnt = (m_cnt < MAXP) ? m_cnt + 1 : MAXP;
      if (m_q == m_start) begin
        m_wrap = 1; m_period = m_cnt; m_cnt = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q"}, 32'(q_o), 32'(m_q));
    check({tag, ".lockup"}, 32'(lockup_o), 32'(m_lock));
`ifdef LFSR_PERIOD_EN
    check({tag, ".wrap"}, 32'(wrap_o), 32'(m_wrap));
    check({tag, ".period"}, 32'(period_o), 32'(m_period));
`else
    check({tag, ".wrap"}, 32'(wrap_o), 32'd0);
    check({tag, ".period"}, 32'(period_o), 32'd0);
`endif
  endtask

  // drive one cycle, advance the model across the edge, sample 1 time unit later
  task automatic cyc(input bit r, input bit e, input bit l, input logic [15:0] s);
    reset_i = r; en_i = e; load_i = l; seed_in_i = s;
    @(posedge clk_i);
    model_update(r, e, l, int'(s));
    #1;
  endtask

  initial begin
    int steps;
    bit seen;
    // reset and step
    cyc(1, 0, 0, 16'h0);
    cyc(1, 0, 0, 16'h0);
    check("reset.q", 32'(q_o), 32'h0000ACE1);
    check("reset.lockup", 32'(lockup_o), 32'd0);
    check("reset.wrap", 32'(wrap_o), 32'd0);
    check("reset.period", 32'(period_o), 32'd0);
    cyc(0, 1, 0, 16'h0); check("step1", 32'(q_o), 32'h000059C3);
    cyc(0, 1, 0, 16'h0); check("step2", 32'(q_o), 32'h0000B387);
    cyc(0, 1, 0, 16'h0); check("step3", 32'(q_o), 32'h0000670F);
    compare_all("step3m");

    // gating: hold for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 16'h1234);
      check("hold.q", 32'(q_o), 32'h0000670F);
    end
    compare_all("hold");

    // LOAD wins over EN
    cyc(0, 1, 1, 16'h0001); check("load.q", 32'(q_o), 32'h00000001);
    cyc(0, 1, 0, 16'h0);    check("load.step", 32'(q_o), 32'h00000002);
    compare_all("load");

    // lock-up: load 0, zero for exactly one cycle, then SEED with a 1-cycle LOCKUP
    cyc(0, 1, 1, 16'h0000);
    check("lock.zero", 32'(q_o), 32'd0);
    check("lock.pre", 32'(lockup_o), 32'd0);
    cyc(0, 1, 1, 16'h5555);
    check("lock.q", 32'(q_o), 32'h0000ACE1);
    check("lock.pulse", 32'(lockup_o), 32'd1);
    cyc(0, 0, 0, 16'h0);
    check("lock.clear", 32'(lockup_o), 32'd0);
    check("lock.hold", 32'(q_o), 32'h0000ACE1);
    compare_all("lock");

    // random stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l;
      logic [15:0] s;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 24) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc(r, e, l, s);
      compare_all("rand");
    end

`ifdef LFSR_PERIOD_EN
    // reset mid-loop, then one full loop from release
    cyc(1, 0, 0, 16'h0);
    for (int i = 0; i < 3000; i++) cyc(0, 1, 0, 16'h0);
    compare_all("mid");
    cyc(1, 1, 0, 16'h0);
    check("midrst.q", 32'(q_o), 32'h0000ACE1);
    check("midrst.period", 32'(period_o), 32'd0);
    steps = 0;
    seen = 0;
    reset_i = 0; en_i = 1; load_i = 0;
    while (!seen && steps < 70000) begin
      @(posedge clk_i); #1;
      steps++;
      if (wrap_o) seen = 1;
    end
    check("loop.seen", 32'(seen), 32'd1);
    check("loop.steps", 32'(steps), 32'd65535);
    check("loop.q", 32'(q_o), 32'h0000ACE1);
    check("loop.period", 32'(period_o), 32'd65535);
    en_i = 0;
    @(posedge clk_i); #1;
    check("loop.wrapclr", 32'(wrap_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
